// File: rtl/optic_flow_color_pkg.sv
// optic_flow_color_pkg
// Shared definitions for the optic-flow palette custom instruction:
// opcode encoding, histogram selectors, palette geometry and the reset
// colouring of the 16 flow codes.
package optic_flow_color_pkg;

  localparam int PAL_DEPTH = 16;
  localparam int COLOR_W   = 16;

  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {
    OP_CONVERT = 2'd0,
    OP_WRITE   = 2'd1,
    OP_READ    = 2'd2,
    OP_HIST    = 2'd3
  } opcode_e;

  // Selector d (0..3) reads the counter for flow-code bit d.
  localparam logic [2:0] HSEL_RIGHT   = 3'd0;
  localparam logic [2:0] HSEL_LEFT    = 3'd1;
  localparam logic [2:0] HSEL_DOWN    = 3'd2;
  localparam logic [2:0] HSEL_UP      = 3'd3;
  localparam logic [2:0] HSEL_CONVERT = 3'd4;

  // Fixed direction colouring for code {u,d,l,r}.
  function automatic color_t default_color(input logic [3:0] code);
    logic u, d, l, r;
    {u, d, l, r} = code;
    return {(l | d), 4'b0, (r | d), 5'b0, (u | d), 4'b0};
  endfunction

endpackage

// File: rtl/optic_flow_palette_ci_if.sv
// optic_flow_palette_ci_if
// CPU custom-instruction bus: start/ciN/valueA/valueB from the CPU,
// done/result back from the CI block.
//   master : CPU side (drives request, receives done/result)
//   slave  : CI block side
interface optic_flow_palette_ci_if;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  modport master (output start, ciN, valueA, valueB, input done, result);
  modport slave  (input start, ciN, valueA, valueB, output done, result);
endinterface

// File: rtl/optic_flow_palette_ci_palette.sv
// optic_flow_palette
// 16x16 colour register file, synchronous reset to default_color().
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   we, waddr, wdata     : single write port
//   raddr0/1, rdata0/1   : combinational pixel0/pixel1 read ports
//   raddr2, rdata2       : combinational read port for the READ opcode
module optic_flow_palette
  import optic_flow_color_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       we,
  input  logic [3:0] waddr,
  input  color_t     wdata,
  input  logic [3:0] raddr0,
  output color_t     rdata0,
  input  logic [3:0] raddr1,
  output color_t     rdata1,
  input  logic [3:0] raddr2,
  output color_t     rdata2
);

  color_t mem [PAL_DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PAL_DEPTH; i++) mem[i] <= default_color(4'(i));
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/optic_flow_palette_ci.sv
// optic_flow_palette_ci
// Custom instruction converting packed 4-bit flow codes into RGB565 pixel
// pairs through a programmable palette, with optional per-frame saturating
// direction histograms.
// Optional feature macro: OPTIC_FLOW_HISTOGRAM_EN (counters + HIST opcode).
// Ports:
//   clock  : system clock
//   reset  : synchronous active-high reset
//   ci     : custom-instruction bus (slave modport)
// Parameters:
//   customInstructionId : CI number this block answers to
//   COUNTER_WIDTH       : histogram counter width (4..32)
module optic_flow_palette_ci
  import optic_flow_color_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int         COUNTER_WIDTH       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  optic_flow_palette_ci_if.slave ci
);

  logic        go;
  opcode_e     opcode;
  logic [7:0]  flow_byte;
  logic [3:0]  code0, code1;
  color_t      pix0, pix1, rd_color;
  logic [31:0] hist_val;
  logic [31:0] result_next;
  logic        done_q;
  logic [31:0] result_q;

  assign go     = ci.start && (ci.ciN == customInstructionId);
  assign opcode = opcode_e'(ci.valueB[9:8]);

  // Group g selects byte g of valueA: low nibble pixel0, high nibble pixel1.
  assign flow_byte = 8'(ci.valueA >> {ci.valueB[1:0], 3'b000});
  assign code0     = flow_byte[3:0];
  assign code1     = flow_byte[7:4];

  optic_flow_palette u_palette (
    .clock  (clock),
    .reset  (reset),
    .we     (go && (opcode == OP_WRITE)),
    .waddr  (ci.valueB[3:0]),
    .wdata  (ci.valueA[15:0]),
    .raddr0 (code0),
    .rdata0 (pix0),
    .raddr1 (code1),
    .rdata1 (pix1),
    .raddr2 (ci.valueB[3:0]),
    .rdata2 (rd_color)
  );

`ifdef OPTIC_FLOW_HISTOGRAM_EN
  logic [COUNTER_WIDTH-1:0] cnt [0:4];
  logic [1:0]               inc_dir [4];

  // Sum is formed two bits wider than the counter so the saturation
  // compare sees the true value instead of a wrapped one.
  function automatic logic [COUNTER_WIDTH-1:0] sat_add(
    input logic [COUNTER_WIDTH-1:0] c,
    input logic [1:0]               inc
  );
    logic [COUNTER_WIDTH+1:0] sum;
    sum = {2'b00, c} + (COUNTER_WIDTH+2)'(inc);
    if (sum > {2'b00, {COUNTER_WIDTH{1'b1}}}) return '1;
    return sum[COUNTER_WIDTH-1:0];
  endfunction

  always_comb begin
    for (int d = 0; d < 4; d++) inc_dir[d] = {1'b0, code0[d]} + {1'b0, code1[d]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else if (go && (opcode == OP_HIST) && ci.valueB[4]) begin
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else if (go && (opcode == OP_CONVERT)) begin
      for (int d = 0; d < 4; d++) cnt[d] <= sat_add(cnt[d], inc_dir[d]);
      cnt[HSEL_CONVERT] <= sat_add(cnt[HSEL_CONVERT], 2'd1);
    end
  end

  always_comb begin
    hist_val = '0;
    case (ci.valueB[2:0])
      HSEL_RIGHT:   hist_val = 32'(cnt[HSEL_RIGHT]);
      HSEL_LEFT:    hist_val = 32'(cnt[HSEL_LEFT]);
      HSEL_DOWN:    hist_val = 32'(cnt[HSEL_DOWN]);
      HSEL_UP:      hist_val = 32'(cnt[HSEL_UP]);
      HSEL_CONVERT: hist_val = 32'(cnt[HSEL_CONVERT]);
      default:      hist_val = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{ci.valueB[31:10], ci.valueB[7:5]};
`else
  assign hist_val = '0;

  logic unused_bits;
  assign unused_bits = ^{ci.valueB[31:10], ci.valueB[7:4]};
`endif

  always_comb begin
    result_next = '0;
    case (opcode)
      OP_CONVERT: result_next = {pix1, pix0};
      OP_WRITE:   result_next = '0;
      OP_READ:    result_next = {16'd0, rd_color};
      OP_HIST:    result_next = hist_val;
      default:    result_next = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q   <= go;
      result_q <= go ? result_next : '0;
    end
  end

  assign ci.done   = done_q;
  assign ci.result = result_q;

endmodule

// File: tb/tb_optic_flow_palette_ci.sv
module tb_optic_flow_palette_ci;

  localparam logic [7:0] CI_ID = 8'd0;
  localparam int         CW    = 4;

  logic clock;
  logic reset;
  optic_flow_palette_ci_if bus ();

  optic_flow_palette_ci #(
    .customInstructionId (CI_ID),
    .COUNTER_WIDTH       (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ci    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state
  int unsigned      pal [16];
  longint unsigned  cnt [5];
  logic             exp_done;
  logic [31:0]      exp_result;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned ref_default(input int code);
    int u, d, l, r;
    r = code & 1; l = (code >> 1) & 1; d = (code >> 2) & 1; u = (code >> 3) & 1;
    return ((l | d) << 15) | ((r | d) << 10) | ((u | d) << 4);
  endfunction

  // Reference model: applies one cycle's request and records what the
  // DUT must show during the following cycle.
  task automatic model(input bit st, input logic [7:0] n, input logic [31:0] a,
                       input logic [31:0] b, input bit rs);
    int op, g, c0, c1, sel;
    longint unsigned cmax;
    cmax = (64'd1 << CW) - 1;
    exp_done   = 1'b0;
    exp_result = '0;
    if (rs) begin
      for (int i = 0; i < 16; i++) pal[i] = ref_default(i);
      for (int i = 0; i < 5; i++) cnt[i] = 0;
    end else if (st && n == CI_ID) begin
      exp_done = 1'b1;
      op  = (b >> 8) & 3;
      g   = b & 3;
      c0  = (a >> (8 * g)) & 15;
      c1  = (a >> (8 * g + 4)) & 15;
      sel = b & 7;
      case (op)
        0: begin
          exp_result = (pal[c1] << 16) | pal[c0];
`ifdef OPTIC_FLOW_HISTOGRAM_EN
          for (int d = 0; d < 4; d++) begin
            cnt[d] += ((c0 >> d) & 1) + ((c1 >> d) & 1);
            if (cnt[d] > cmax) cnt[d] = cmax;
          end
          cnt[4] += 1;
          if (cnt[4] > cmax) cnt[4] = cmax;
`endif
        end
        1: pal[b & 15] = a & 32'hFFFF;
        2: exp_result = pal[b & 15];
        default: begin
`ifdef OPTIC_FLOW_HISTOGRAM_EN
          exp_result = (sel < 5) ? 32'(cnt[sel]) : 32'd0;
          if ((b >> 4) & 1) for (int i = 0; i < 5; i++) cnt[i] = 0;
`else
          exp_result = 32'd0;
`endif
        end
      endcase
    end
  endtask

  // One bus cycle: check the outputs from the previous request, then
  // present the next request.
  task automatic cycle(input string tag, input bit st, input logic [7:0] n,
                       input logic [31:0] a, input logic [31:0] b, input bit rs);
    @(negedge clock);
    check_eq({tag, ".done"}, 32'(bus.done), 32'(exp_done));
    check_eq({tag, ".result"}, bus.result, exp_result);
    bus.start  = st;
    bus.ciN    = n;
    bus.valueA = a;
    bus.valueB = b;
    reset      = rs;
    model(st, n, a, b, rs);
  endtask

  task automatic op(input string tag, input int opc, input logic [31:0] a, input logic [31:0] b);
    cycle(tag, 1'b1, CI_ID, a, (32'(opc) << 8) | b, 1'b0);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, CI_ID, '0, '0, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.ciN    = CI_ID;
    bus.valueA = '0;
    bus.valueB = '0;
    exp_done   = 1'b0;
    exp_result = '0;
    model(1'b0, CI_ID, '0, '0, 1'b1);

    cycle("rst", 1'b0, CI_ID, '0, '0, 1'b1);
    idle("rst_out");
    idle("idle");

    op("conv48", 0, 32'h0000_0048, 32'd0);
    op("wr5", 1, 32'h0000_ABCD, 32'd5);
    op("conv55", 0, 32'h0000_0055, 32'd0);
    op("rd5", 2, 32'd0, 32'd5);
    op("conv_g2", 0, 32'h00C3_0000, 32'd2);
    op("conv_g3", 0, 32'h9A00_0000, 32'd3);
    idle("idle2");

    op("b2b_wr", 1, 32'h0000_1234, 32'd9);
    op("b2b_rd", 2, 32'd0, 32'd9);
    op("b2b_cv", 0, 32'h0000_0099, 32'd0);
    op("b2b_hs", 3, 32'd0, 32'd4);
    cycle("wrong_ci", 1'b1, 8'h42, 32'h0000_FFFF, 32'h0000_0103, 1'b0);
    idle("after_wrong");

    for (int i = 0; i < 16; i++) op("rd_all", 2, 32'd0, 32'(i));

    op("hclr", 3, 32'd0, 32'h14);
    for (int i = 0; i < 3; i++) op("h_conv", 0, 32'hFFFF_FFFF, 32'd0);
    op("h_right", 3, 32'd0, 32'd0);
    op("h_up", 3, 32'd0, 32'd3);
    op("h_cnt_clr", 3, 32'd0, 32'h14);
    op("h_cnt0", 3, 32'd0, 32'd4);
    op("h_sel7", 3, 32'd0, 32'd7);

    for (int i = 0; i < 9; i++) op("sat_conv", 0, 32'hFFFF_FFFF, 32'd0);
    op("sat_right", 3, 32'd0, 32'd0);
    op("sat_cnt", 3, 32'd0, 32'd4);

    cycle("rst_wr0", 1'b1, CI_ID, 32'h0000_5555, 32'h0000_0100, 1'b1);
    op("rd0", 2, 32'd0, 32'd0);
    idle("idle3");

    for (int i = 0; i < 400; i++) begin
      logic [7:0]  n;
      logic [31:0] b;
      n = ($urandom_range(0, 7) == 0) ? 8'h5A : CI_ID;
      b = $urandom & 32'h0000_031F;
      if ($urandom_range(0, 3) == 0) b = (b & 32'hFFFF_FFE0) | 32'($urandom_range(0, 7));
      cycle("rand", 1'($urandom_range(0, 4) != 0), n, $urandom, b,
            ($urandom_range(0, 59) == 0));
    end
    idle("drain");
    idle("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
